// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and operation-class helper shared by alu_seq_ctrl and alu8_core.
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SUBA = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op <= OP_SUBA;
    endfunction
endpackage

// File: rtl/alu_seq_ctrl_alu8_core.sv
// alu8_core: combinational 8-bit ALU; arithmetic is 9-bit on zero-extended operands.
module alu8_core
    import alu_seq_pkg::*;
(
    input  logic [2:0] oper,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);
    logic [8:0] s9;

    always_comb begin
        s9 = '0;
        case (oper)
            OP_ADD:  s9 = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
            OP_SUB:  s9 = {1'b0, a} + {1'b0, ~b} + {8'b0, c_in};
            OP_SUBA: s9 = {1'b0, b} + {1'b0, ~a} + {8'b0, ~c_in};
            OP_OR:   s9 = {1'b0, a | b};
            OP_AND:  s9 = {1'b0, a & b};
            OP_ANDN: s9 = {1'b0, ~a & b};
            OP_XOR:  s9 = {1'b0, a ^ b};
            OP_XNOR: s9 = {1'b0, ~(a ^ b)};
            default: s9 = '0;
        endcase
    end

    assign sum   = s9[7:0];
    assign c_out = s9[8];
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: byte-serial multi-precision sequencer around one alu8_core, LSB first with chained carry.
// Defining ALU_SEQ_FLAGS_EN adds registered zero/ovf result flags.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic [2:0]            oper,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  c_in,
    output logic [8*NBYTES-1:0]   res,
    output logic                  c_out,
    output logic                  res_valid,
    input  logic                  res_ready
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  ovf
`endif
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cr_q, cr_d, co_q, co_d, rdy_q, rdy_d, vld_q, vld_d;
    logic [7:0]      ca, cb, cs;
    logic            cci, cco, last, acc;

    assign ca   = a_q[{idx_q, 3'b000} +: 8];
    assign cb   = b_q[{idx_q, 3'b000} +: 8];
    assign last = idx_q == IW'(NBYTES - 1);
    assign acc  = start & rdy_q;
    // sub_a re-inverts its carry in the core, so later bytes pre-invert to chain the true c_out
    assign cci  = (op_q == OP_ADD || op_q == OP_SUB) ? cr_q :
                  (op_q == OP_SUBA) ? ((idx_q == '0) ? cr_q : ~cr_q) : 1'b0;

    alu8_core u_core (
        .oper  (op_q),
        .a     (ca),
        .b     (cb),
        .c_in  (cci),
        .sum   (cs),
        .c_out (cco)
    );

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, zero_d, ovf_q, ovf_d, x7, y7;
    assign x7   = (op_q == OP_SUBA) ? cb[7] : ca[7];
    assign y7   = (op_q == OP_ADD) ? cb[7] : (op_q == OP_SUB) ? ~cb[7] : ~ca[7];
    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cr_d    = cr_q;
        co_d    = co_q;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        if (acc) begin
            state_d = S_RUN;
            op_d    = oper;
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            idx_d   = '0;
            cr_d    = c_in;
            co_d    = 1'b0;
        end else if (state_q == S_RUN) begin
            res_d[{idx_q, 3'b000} +: 8] = cs;
            cr_d  = cco;
            idx_d = last ? idx_q : idx_q + 1'b1;
            if (last) begin
                state_d = S_DONE;
                co_d    = is_arith(op_q) & cco;
`ifdef ALU_SEQ_FLAGS_EN
                zero_d  = res_d == '0;
                ovf_d   = is_arith(op_q) & (x7 == y7) & (cs[7] != x7);
`endif
            end
        end else if (state_q == S_DONE && res_ready) begin
            state_d = S_IDLE;
        end
        rdy_d = state_d == S_IDLE;
        vld_d = state_d == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cr_q    <= 1'b0;
            co_q    <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cr_q    <= cr_d;
            co_q    <= co_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready     = rdy_q;
    assign res       = res_q;
    assign c_out     = co_q;
    assign res_valid = vld_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of alu_seq_ctrl (NBYTES=4) against a whole-word reference model.
module tb_alu_seq_ctrl;
    logic        clk = 0;
    logic        rst_n, start, ready, c_in, c_out, res_valid, res_ready;
    logic [2:0]  oper;
    logic [31:0] a, b, res;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero, ovf;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .oper      (oper),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .res       (res),
        .c_out     (c_out),
        .res_valid (res_valid),
        .res_ready (res_ready)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // whole-word model: {final carry, result}
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
        case (op)
            3'd0: return {1'b0, x} + {1'b0, y} + 33'(ci);
            3'd1: return {1'b0, x} + {1'b0, ~y} + 33'(ci);
            3'd2: return {1'b0, y} + {1'b0, ~x} + 33'(!ci);
            3'd3: return {1'b0, x | y};
            3'd4: return {1'b0, x & y};
            3'd5: return {1'b0, ~x & y};
            3'd6: return {1'b0, x ^ y};
            default: return {1'b0, ~(x ^ y)};
        endcase
    endfunction

    // request one operation, scramble inputs after accept, wait (bounded) for res_valid
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic ci,
                         output int lat);
        oper = op; a = x; b = y; c_in = ci; start = 1;
        @(posedge clk); #1;
        start = 0; oper = 3'($urandom); a = $urandom; b = $urandom; c_in = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL rst_res: got %h want 0", res); end
        n_cmp++; if (c_out !== 1'b0) begin n_bad++; $display("FAIL rst_cout: got %b want 0", c_out); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    endtask

    task automatic test_directed;
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [31:0] xs  [6] = '{32'h000000FF, 32'h0, 32'h5, 32'h1, 32'hF0F0F0F0, 32'hFFFFFFFF};
        logic [31:0] ys  [6] = '{32'h00000001, 32'h1, 32'h3, 32'h3, 32'h0F0F0F0F, 32'h00000001};
        logic        cis [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ers [6] = '{32'h00000100, 32'hFFFFFFFF, 32'h2, 32'h2, 32'hFFFFFFFF, 32'h0};
        logic        ecs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xs[i], ys[i], cis[i], lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL dir_lat[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (res !== ers[i]) begin n_bad++; $display("FAIL dir_res[%0d]: got %h want %h", i, res, ers[i]); end
            n_cmp++; if (c_out !== ecs[i]) begin n_bad++; $display("FAIL dir_cout[%0d]: got %b want %b", i, c_out, ecs[i]); end
            res_ready = 1;
            @(posedge clk); #1;
            res_ready = 0;
            n_cmp++; if (ready !== 1'b1 || res_valid !== 1'b0) begin
                n_bad++; $display("FAIL dir_hs[%0d]: got ready=%b valid=%b want 1/0", i, ready, res_valid);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] x, y;
        logic        ci, rr;
        logic [32:0] e;
        int lat, d;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); x = $urandom; y = $urandom; ci = 1'($urandom);
            if (i % 5 == 0) y = ~x;
            if (i % 7 == 0) y = x;
            e = model(op, x, y, ci);
            rr = 1'($urandom);
            res_ready = rr;
            issue(op, x, y, ci, lat);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (res !== e[31:0]) begin n_bad++; $display("FAIL rnd_res[%0d] op=%0d: got %h want %h", i, op, res, e[31:0]); end
            n_cmp++; if (c_out !== e[32]) begin n_bad++; $display("FAIL rnd_cout[%0d] op=%0d: got %b want %b", i, op, c_out, e[32]); end
            if (!rr) begin
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(posedge clk); #1;
                    n_cmp++; if (res !== e[31:0] || res_valid !== 1'b1) begin
                        n_bad++; $display("FAIL rnd_hold[%0d]: got %h/%b want %h/1", i, res, res_valid, e[31:0]);
                    end
                end
                res_ready = 1;
            end
            @(posedge clk); #1;
            res_ready = 0;
            n_cmp++; if (ready !== 1'b1 || res_valid !== 1'b0) begin
                n_bad++; $display("FAIL rnd_hs[%0d]: got ready=%b valid=%b want 1/0", i, ready, res_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [32:0] e;
        int lat;
        e = model(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        res_ready = 0;
        issue(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1, lat);
        for (int i = 0; i < 3; i++) begin
            start = 1; a = $urandom; b = $urandom; oper = 3'($urandom);
            @(posedge clk); #1;
            n_cmp++; if (res !== e[31:0] || c_out !== e[32]) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/%b", i, res, c_out, e[31:0], e[32]);
            end
            n_cmp++; if (ready !== 1'b0 || res_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_state[%0d]: got ready=%b valid=%b want 0/1", i, ready, res_valid);
            end
        end
        start = 0; res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        n_cmp++; if (ready !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", ready, res_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bp_not_queued: got ready=%b want 1", ready); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        oper = 3'd0; a = 32'h01010101; b = 32'h01010101; c_in = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (res !== 32'h00000202) begin n_bad++; $display("FAIL mid_partial: got %h want 00000202", res); end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        n_cmp++; if (ready !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_state: got ready=%b valid=%b want 1/0", ready, res_valid);
        end
        n_cmp++; if (res !== 32'h0 || c_out !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_res: got %h/%b want 0/0", res, c_out);
        end
        issue(3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL post_lat: got %0d want 4", lat); end
        n_cmp++; if (res !== 32'h80000000 || c_out !== 1'b0) begin
            n_bad++; $display("FAIL post_res: got %h/%b want 80000000/0", res, c_out);
        end
`ifdef ALU_SEQ_FLAGS_EN
        n_cmp++; if (ovf !== 1'b1 || zero !== 1'b0) begin
            n_bad++; $display("FAIL post_flags: got ovf=%b zero=%b want 1/0", ovf, zero);
        end
`endif
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    initial begin
        rst_n = 0; start = 0; res_ready = 0; oper = 0; a = 0; b = 0; c_in = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1;
        @(posedge clk); #1;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
